imem_loader: RTL

Parametrised instruction memory for the RISC-V core with a runtime byte-stream program loader and a registered fetch port. The program image is no longer fixed at elaboration: an external loader (UART bridge or testbench) streams little-endian bytes in, and the fetch stage reads 32-bit words through a request/valid handshake. It replaces the fixed-content instruction ROM and adds fault reporting for misaligned and out-of-range fetches.

---
 rtl/imem_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory with byte-stream program loader and registered fetch port
module imem_loader #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_byte_valid,
    input  logic [7:0]        ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_fault
);

    localparam int BYTE_AW = $clog2(DEPTH_WORDS * 4);
    localparam int WORD_AW = BYTE_AW - 2;
    localparam int CNT_W   = BYTE_AW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    logic [0:0]             state;
    logic [CNT_W-1:0]       byte_cnt;
    logic [DEPTH_WORDS-1:0] written;
    logic [31:0]            mem [DEPTH_WORDS];

    logic               byte_acc;
    logic               in_range;
    logic               wr_en;
    logic [WORD_AW-1:0] wr_word;
    logic [1:0]         wr_lane;
    logic               fetch_acc;
    logic [WORD_AW-1:0] rd_word;
    logic               misaligned;
    logic               out_of_range;

    assign fetch_ready = (state == ST_RUN);
    assign ld_ready    = (state == ST_LOAD);

    // ld_start takes priority: a byte presented alongside it is dropped
    assign byte_acc = ld_ready && ld_byte_valid && !ld_start;
    // counter top bit set means the image has filled the whole array
    assign in_range = !byte_cnt[CNT_W-1];
    assign wr_en    = byte_acc && in_range;
    assign wr_word  = byte_cnt[BYTE_AW-1:2];
    assign wr_lane  = byte_cnt[1:0];

    assign fetch_acc    = fetch_req && fetch_ready;
    assign rd_word      = fetch_addr[BYTE_AW-1:2];
    assign misaligned   = |fetch_addr[1:0];
    assign out_of_range = (fetch_addr >> BYTE_AW) != '0;

    // Array carries no reset; the written bits decide what is visible
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_lane == 2'd0) begin
                mem[wr_word] <= {24'h000000, ld_byte};
            end else begin
                mem[wr_word][{wr_lane, 3'b000} +: 8] <= ld_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            byte_cnt    <= '0;
            written     <= '0;
            ld_done     <= 1'b0;
            ld_err      <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_instr <= NOP_INSTR;
            fetch_fault <= 1'b0;
        end else begin
            ld_done     <= byte_acc && ld_last;
            fetch_valid <= fetch_acc;

            if (fetch_acc) begin
                if (misaligned || out_of_range) begin
                    fetch_fault <= 1'b1;
                    fetch_instr <= NOP_INSTR;
                end else begin
                    fetch_fault <= 1'b0;
                    fetch_instr <= written[rd_word] ? mem[rd_word] : NOP_INSTR;
                end
            end

            if (ld_start) begin
                state    <= ST_LOAD;
                byte_cnt <= '0;
                written  <= '0;
                ld_err   <= 1'b0;
            end else if (byte_acc) begin
                if (in_range) begin
                    byte_cnt <= byte_cnt + 1'b1;
                    if (wr_lane == 2'd0) begin
                        written[wr_word] <= 1'b1;
                    end
                end else begin
                    ld_err <= 1'b1;
                end
                if (ld_last) begin
                    state <= ST_RUN;
                end
            end
        end
    end

endmodule
